data_memory_responder: RTL

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder.sv | 106 ++++++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder: byte-addressed big-endian word memory with a fixed-latency request/response handshake
module data_memory_responder #(
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WINIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          write_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [7:0]    mem_q [DEPTH];

    logic          accept;
    logic          req_err;
    logic          op_go;
    logic          op_write;
    logic [AW-1:0] op_addr;
    logic [31:0]   op_wdata;
    logic [31:0]   rd_word;

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign accept    = req_valid && req_ready;
    assign req_err   = (req_addr[1:0] != 2'b00) || (({1'b0, req_addr} + 33'd3) >= 33'(DEPTH));

    // Memory operation fires on the edge entering RESP; with zero wait states it comes straight from the inputs
    always_comb begin
        op_go    = ((state_q == WAIT) && (cnt_q == 4'd0)) || ((WAIT_CYCLES == 0) && accept && !req_err);
        op_write = (state_q == IDLE) ? req_write : write_q;
        op_addr  = (state_q == IDLE) ? req_addr[AW-1:0] : addr_q;
        op_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
        rd_word  = {mem_q[op_addr], mem_q[op_addr + AW'(1)], mem_q[op_addr + AW'(2)], mem_q[op_addr + AW'(3)]};
    end

    // Control FSM: latches the accepted request, counts wait states and registers the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    write_q <= req_write;
                    addr_q  <= req_addr[AW-1:0];
                    wdata_q <= req_wdata;
                    if (req_err) begin
                        state_q    <= RESP;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                    end else if (WAIT_CYCLES == 0) begin
                        state_q    <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= req_write ? 32'd0 : rd_word;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= WINIT;
                    end
                end
                WAIT: if (cnt_q == 4'd0) begin
                    state_q    <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= write_q ? 32'd0 : rd_word;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage is never reset; a store commits all four bytes big-endian
    always_ff @(posedge clk) begin
        if (rst_n && op_go && op_write) begin
            mem_q[op_addr]          <= op_wdata[31:24];
            mem_q[op_addr + AW'(1)] <= op_wdata[23:16];
            mem_q[op_addr + AW'(2)] <= op_wdata[15:8];
            mem_q[op_addr + AW'(3)] <= op_wdata[7:0];
        end
    end
endmodule
